// File: rtl/keypad_keys.sv
// keypad_keys: consumer side of the keypad scanner.
// Remaps the physical 4x4 matrix snapshot onto CHIP-8 key indices and
// debounces every key independently. Serves EX9E/EXA1 through a
// combinational lookup and FX0A through a req/ack wait handshake.
module keypad_keys #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    output logic [15:0] keys,
    input  logic [3:0]  query_key,
    output logic        query_down,
    input  logic        wait_req,
    output logic        wait_ack,
    output logic [3:0]  wait_key
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        DONE         = 2'd3
    } state_t;

    // Lowest set bit index, so simultaneous presses resolve to the smallest key.
    function automatic logic [3:0] lowest_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            idx = v[i] ? 4'(i) : idx;
        end
        return idx;
    endfunction

    logic [15:0]   raw_s;
    logic [15:0]   keys_r;
    logic [15:0]   keys_q_r;
    logic [15:0]   pressed_edge_s;
    logic [CW-1:0] cnt_r [16];
    state_t        state_r;
    state_t        state_next_s;
    logic          wait_ack_r;
    logic          ack_next_s;
    logic [3:0]    wait_key_r;
    logic [3:0]    key_next_s;

    // Physical bit 15-(4*col+row) to CHIP-8 key index, MSB = key F.
    assign raw_s = {value[0],  value[1],  value[2],  value[3],
                    value[4],  value[12], value[5],  value[9],
                    value[13], value[6],  value[10], value[14],
                    value[7],  value[11], value[15], value[8]};

    assign pressed_edge_s = keys_r & ~keys_q_r;

    // Per-key debounce: flip only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            keys_r <= 16'h0000;
            for (int i = 0; i < 16; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (raw_s[i] == keys_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == CNT_LAST) begin
                    keys_r[i] <= raw_s[i];
                    cnt_r[i]  <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CW'(1);
                end
            end
        end
    end

    // One-cycle delayed copy of the debounced keys for press-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            keys_q_r <= 16'h0000;
        end else begin
            keys_q_r <= keys_r;
        end
    end

    // FX0A wait FSM state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            wait_ack_r <= 1'b0;
            wait_key_r <= 4'h0;
        end else begin
            state_r    <= state_next_s;
            wait_ack_r <= ack_next_s;
            wait_key_r <= key_next_s;
        end
    end

    // FX0A next-state logic: capture a new press, ack on its release.
    always_comb begin
        state_next_s = state_r;
        ack_next_s   = 1'b0;
        key_next_s   = wait_key_r;
        case (state_r)
            IDLE: begin
                if (wait_req) begin
                    state_next_s = WAIT_PRESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_PRESS: begin
                if (!wait_req) begin
                    state_next_s = IDLE;
                end else if (pressed_edge_s != 16'h0000) begin
                    key_next_s   = lowest_index(pressed_edge_s);
                    state_next_s = WAIT_RELEASE;
                end else begin
                    state_next_s = WAIT_PRESS;
                end
            end
            WAIT_RELEASE: begin
                if (!wait_req) begin
                    state_next_s = IDLE;
                end else if (!keys_r[wait_key_r]) begin
                    ack_next_s   = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = WAIT_RELEASE;
                end
            end
            DONE: begin
                if (!wait_req) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign keys       = keys_r;
    assign query_down = keys_r[query_key];
    assign wait_ack   = wait_ack_r;
    assign wait_key   = wait_key_r;

endmodule

// File: tb/tb_keypad_keys.sv
// Self-checking bench for keypad_keys: table-driven remap vectors,
// hand-written handshake sequences and a randomized run, all compared
// against a sample-history reference model.
module tb_keypad_keys;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [15:0] keys;
    logic [3:0]  query_key;
    logic        query_down;
    logic        wait_req;
    logic        wait_ack;
    logic [3:0]  wait_key;

    keypad_keys #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .value(value), .keys(keys),
        .query_key(query_key), .query_down(query_down),
        .wait_req(wait_req), .wait_ack(wait_ack), .wait_key(wait_key)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int ack_count = 0;

    // Reference model state
    int          key_at [4][4] = '{'{1, 2, 3, 12}, '{4, 5, 6, 13}, '{7, 8, 9, 14}, '{10, 0, 11, 15}};
    logic [15:0] hist [$];
    logic [15:0] keys_m = 16'h0000;
    logic [15:0] keys_prev_m = 16'h0000;
    int          mode_m = 0;          // 0 idle, 1 awaiting press, 2 awaiting release, 3 acked
    logic [3:0]  key_m = 4'h0;
    logic        ack_m = 1'b0;

    typedef struct {
        int         row;
        int         col;
        logic [3:0] key;
    } map_vec_t;
    map_vec_t vecs [16];

    function automatic logic [15:0] phys_bit(input int row, input int col);
        logic [15:0] one;
        one = 16'h0001;
        return one << (15 - (4 * col + row));
    endfunction

    function automatic logic [15:0] remap(input logic [15:0] v);
        logic [15:0] res;
        res = 16'h0000;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[key_at[r][c]] = v[15 - (4 * c + r)];
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic [15:0] edges;
        bit found;
        bit all_diff;
        if (reset) begin
            keys_m = 16'h0000; keys_prev_m = 16'h0000;
            mode_m = 0; key_m = 4'h0; ack_m = 1'b0;
            hist.delete();
            return;
        end
        edges = keys_m & ~keys_prev_m;
        ack_m = 1'b0;
        case (mode_m)
            0: if (wait_req) mode_m = 1;
            1: begin
                if (!wait_req) mode_m = 0;
                else if (edges != 16'h0000) begin
                    found = 0;
                    for (int k = 0; k < 16; k++)
                        if (!found && edges[k]) begin key_m = 4'(k); found = 1; end
                    mode_m = 2;
                end
            end
            2: begin
                if (!wait_req) mode_m = 0;
                else if (!keys_m[key_m]) begin ack_m = 1'b1; mode_m = 3; end
            end
            default: if (!wait_req) mode_m = 0;
        endcase
        keys_prev_m = keys_m;
        hist.push_back(remap(value));
        if (hist.size() > D) void'(hist.pop_front());
        if (hist.size() == D) begin
            for (int k = 0; k < 16; k++) begin
                all_diff = 1;
                foreach (hist[j]) if (hist[j][k] == keys_m[k]) all_diff = 0;
                if (all_diff) keys_m[k] = ~keys_m[k];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cycle++;
        #1;
        if (wait_ack === 1'b1) ack_count++;
        check("keys", 32'(keys), 32'(keys_m));
        check("wait_ack", 32'(wait_ack), 32'(ack_m));
        check("wait_key", 32'(wait_key), 32'(key_m));
        check("query_down", 32'(query_down), 32'(keys_m[query_key]));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int fall_cyc;
        int ack_cyc;
        logic [3:0] wk;
        logic prev14;
        int hold;

        vecs[0]  = '{0, 0, 4'h1}; vecs[1]  = '{0, 1, 4'h2}; vecs[2]  = '{0, 2, 4'h3}; vecs[3]  = '{0, 3, 4'hC};
        vecs[4]  = '{1, 0, 4'h4}; vecs[5]  = '{1, 1, 4'h5}; vecs[6]  = '{1, 2, 4'h6}; vecs[7]  = '{1, 3, 4'hD};
        vecs[8]  = '{2, 0, 4'h7}; vecs[9]  = '{2, 1, 4'h8}; vecs[10] = '{2, 2, 4'h9}; vecs[11] = '{2, 3, 4'hE};
        vecs[12] = '{3, 0, 4'hA}; vecs[13] = '{3, 1, 4'h0}; vecs[14] = '{3, 2, 4'hB}; vecs[15] = '{3, 3, 4'hF};

        reset = 1'b1; value = 16'h0000; query_key = 4'h0; wait_req = 1'b0;
        steps(3);
        check("reset_keys", 32'(keys), 32'h0);
        check("reset_ack", 32'(wait_ack), 32'h0);
        check("reset_wait_key", 32'(wait_key), 32'h0);
        reset = 1'b0;

        // 1: debounce latency on physical (r0,c0)
        value = phys_bit(0, 0);
        steps(D - 1);
        check("t1_before_latency", 32'(keys), 32'h0);
        step();
        check("t1_keys_0002", 32'(keys), 32'h0002);
        steps(4);
        value = 16'h0000;
        steps(D + 2);

        // 2: short glitch on r3,c1 ignored, long hold accepted
        query_key = 4'h0;
        value = phys_bit(3, 1);
        steps(10);
        value = 16'h0000;
        steps(D + 2);
        check("t2_glitch", 32'(keys), 32'h0);
        value = phys_bit(3, 1);
        steps(D + 2);
        check("t2_key0", 32'(keys), 32'h0001);
        check("t2_query0", 32'(query_down), 32'h1);
        value = 16'h0000;
        steps(D + 2);

        // Remap table
        for (int i = 0; i < 16; i++) begin
            query_key = vecs[i].key;
            value = phys_bit(vecs[i].row, vecs[i].col);
            steps(D);
            check("map_keys", 32'(keys), 32'(16'h0001 << vecs[i].key));
            check("map_query", 32'(query_down), 32'h1);
            value = 16'h0000;
            steps(D);
            check("map_release", 32'(keys), 32'h0);
        end

        // 3: held key ignored, new key E acked one cycle after its release
        ack_count = 0;
        value = phys_bit(1, 1);
        steps(20);
        wait_req = 1'b1;
        steps(10);
        value = 16'h0000;
        steps(20);
        check("t3_no_ack_held", 32'(ack_count), 32'h0);
        value = phys_bit(2, 3);
        steps(20);
        value = 16'h0000;
        fall_cyc = -100; ack_cyc = -1; wk = 4'h0; prev14 = keys[14];
        for (int i = 0; i < 40; i++) begin
            step();
            if (prev14 && !keys[14]) fall_cyc = cycle;
            if (wait_ack === 1'b1) begin ack_cyc = cycle; wk = wait_key; end
            prev14 = keys[14];
        end
        check("t3_ack_count", 32'(ack_count), 32'h1);
        check("t3_ack_timing", 32'(ack_cyc), 32'(fall_cyc + 1));
        check("t3_wait_key", 32'(wk), 32'hE);
        wait_req = 1'b0;
        steps(3);

        // 4: simultaneous 9 and 3 -> lowest wins
        wait_req = 1'b1;
        steps(3);
        value = phys_bit(2, 2) | phys_bit(0, 2);
        steps(20);
        check("t4_lowest", 32'(wait_key), 32'h3);
        value = 16'h0000;
        steps(20);
        wait_req = 1'b0;
        steps(3);

        // 5: drop req while waiting for release -> no ack
        wait_req = 1'b1;
        steps(2);
        value = phys_bit(2, 0);
        steps(20);
        check("t5_capture7", 32'(wait_key), 32'h7);
        wait_req = 1'b0;
        steps(2);
        ack_count = 0;
        value = 16'h0000;
        steps(25);
        check("t5_no_ack", 32'(ack_count), 32'h0);

        // 6: reset mid-wait, then a held req yields a single ack
        wait_req = 1'b1;
        value = phys_bit(0, 0);
        steps(8);
        reset = 1'b1;
        step();
        check("t6_reset_keys", 32'(keys), 32'h0);
        check("t6_reset_ack", 32'(wait_ack), 32'h0);
        reset = 1'b0;
        ack_count = 0;
        steps(20);
        value = 16'h0000;
        steps(60);
        check("t6_single_ack", 32'(ack_count), 32'h1);
        wait_req = 1'b0;
        steps(2);

        // Randomized run against the model
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0: value = 16'h0000;
                    3: value = phys_bit($urandom_range(0, 3), $urandom_range(0, 3))
                             | phys_bit($urandom_range(0, 3), $urandom_range(0, 3));
                    default: value = phys_bit($urandom_range(0, 3), $urandom_range(0, 3));
                endcase
                hold = $urandom_range(1, 40);
            end
            hold--;
            if ($urandom_range(0, 29) == 0) wait_req = ~wait_req;
            query_key = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 599) == 0);
            step();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
